regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised register file that succeeds the fixed 64-bit tristate register:
//  DEPTH words of WIDTH bits, one byte-masked write port, two combinational read ports.
//  Adds a per-entry busy scoreboard for the pipelined processor; decode uses it to stall on pending producers.
//  Entry 0 is hardwired to zero. Sits between decode (read/reserve) and writeback (write).
// PARAMETERS
//  WIDTH   64  data width in bits; must be a multiple of 8
//  DEPTH   32  number of entries; power of two, >= 2
//  ADDR_W  $clog2(DEPTH)  address width (derived; do not override)
// PORTS
//  clock       in   1         rising-edge clock
//  reset       in   1         asynchronous, active-low reset
//  wr_en       in   1         write strobe, sampled on rising clock
//  wr_addr     in   ADDR_W    write address
//  wr_data     in   WIDTH     write data
//  wr_byte_en  in   WIDTH/8   byte lane enables for the write
//  rd_addr_a   in   ADDR_W    read port A address
//  rd_data_a   out  WIDTH     read port A data (combinational)
//  busy_a      out  1         scoreboard bit for rd_addr_a
//  rd_addr_b   in   ADDR_W    read port B address
//  rd_data_b   out  WIDTH     read port B data (combinational)
//  busy_b      out  1         scoreboard bit for rd_addr_b
//  rsv_en      in   1         reserve strobe: mark rsv_addr busy
//  rsv_addr    in   ADDR_W    entry to reserve
//  flush       in   1         synchronous clear of all busy bits (pipeline flush)
// BEHAVIOUR
//  - Reset (reset=0, async): all entries = 0, all busy bits = 0. Outputs follow reads of zeroed state.
//    Reset asserted mid-write discards that write.
//  - Write: on rising clock with wr_en=1 and wr_addr!=0, each byte lane i with wr_byte_en[i]=1
//    takes wr_data[8i+7:8i]. Other lanes are unchanged.
//  - Write side effect: busy[wr_addr] is cleared on the same edge.
//  - A write with wr_byte_en=0 still clears busy.
//  - Entry 0: writes are ignored. rd_data = 0 and busy = 0 always.
//  - Reserve: on rising clock with rsv_en=1 and rsv_addr!=0, busy[rsv_addr] is set to 1.
//  - Same edge, wr_addr == rsv_addr (nonzero): reserve wins. Data is written and busy stays 1,
//    because a new producer has been issued.
//  - Flush: on rising clock all busy bits clear. Flush has priority over a reserve on the same edge.
//    A write on the same edge still updates data.
//  - Read: rd_data_x = entry[rd_addr_x] and busy_x = busy[rd_addr_x], combinational (zero cycle latency).
//    Ports A and B are fully independent and may use the same address.
//  - A write becomes visible on read ports the cycle after its edge, unless REGFILE_BYPASS_EN is defined.
//  - Out-of-range addresses cannot occur (DEPTH is a power of two).
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: same-cycle write-to-read forwarding applies when wr_en=1 and
//   rd_addr_x == wr_addr != 0.
//   - rd_data_x = byte-merge of wr_data over the stored entry, per wr_byte_en.
//   - busy_x = 0 unless flush=0, rsv_en=1 and rsv_addr == wr_addr (then 1).
//   - Read timing from wr_* becomes a combinational path.
//  REGFILE_BYPASS_EN undefined: no forwarding. Reads return the stored, pre-edge state only.
// TESTING
//  1. Reset: drop reset mid-cycle after writing 5 <- 64'hDEAD_BEEF_0123_4567.
//     -> rd_data_a(5)=0 and busy_a=0 immediately, without waiting for a clock edge.
//  2. Byte mask: write 3 <- 64'hFFFF_FFFF_FFFF_FFFF with all lanes enabled, then
//     write 3 <- 64'h0 with wr_byte_en=8'h0F.
//     -> rd_data_b(3)=64'hFFFF_FFFF_0000_0000.
//  3. Register 0: write 0 <- 64'h1234 with rsv_en on 0.
//     -> rd_data_a(0)=0, busy_a=0 on the following cycle.
//  4. Scoreboard: reserve 7 -> busy_a(7)=1 next cycle. Write 7 <- 64'hAA -> busy=0 and data 64'hAA next cycle.
//     Reserve and write 9 on the same edge -> busy(9)=1, data updated.
//  5. Flush: reserve 2, 4 and 6. Then flush with rsv_en on 8 on the same edge.
//     -> busy for 2, 4, 6 and 8 all read 0.
//  6. Bypass: write 10 <- 64'h55 and read A=10 in the same cycle.
//     -> with REGFILE_BYPASS_EN, rd_data_a=64'h55 in that cycle.
//     -> without it, rd_data_a shows the old value and 64'h55 appears next cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: DEPTH x WIDTH byte-masked register file with busy scoreboard, entry 0 hardwired to zero; define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding
module regfile_scoreboard #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_byte_en,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [WIDTH-1:0]     rd_data_a,
  output logic                 busy_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [WIDTH-1:0]     rd_data_b,
  output logic                 busy_b,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 flush
);
  localparam int LANES = WIDTH / 8;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy, busy_next;
  logic [WIDTH-1:0] merged;
  logic             wr_hit;
  assign wr_hit = wr_en && wr_addr != '0;
  // incoming byte lanes merged over the stored word at the write address
  always_comb begin
    merged = mem[wr_addr];
    for (int i = 0; i < LANES; i++)
      if (wr_byte_en[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
  end
  // scoreboard: writeback retires, a new reservation wins over it, flush clears everything
  always_comb begin
    busy_next = busy;
    if (wr_hit) busy_next[wr_addr] = 1'b0;
    if (rsv_en && rsv_addr != '0) busy_next[rsv_addr] = 1'b1;
    if (flush) busy_next = '0;
    busy_next[0] = 1'b0;
  end
  // storage and busy bits; async reset also drops any write in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_hit) mem[wr_addr] <= merged;
      busy <= busy_next;
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic fwd_busy, hit_a, hit_b;
  assign fwd_busy  = !flush && rsv_en && rsv_addr == wr_addr;
  assign hit_a     = wr_hit && rd_addr_a == wr_addr;
  assign hit_b     = wr_hit && rd_addr_b == wr_addr;
  assign rd_data_a = rd_addr_a == '0 ? '0 : hit_a ? merged : mem[rd_addr_a];
  assign rd_data_b = rd_addr_b == '0 ? '0 : hit_b ? merged : mem[rd_addr_b];
  assign busy_a    = hit_a ? fwd_busy : busy[rd_addr_a];
  assign busy_b    = hit_b ? fwd_busy : busy[rd_addr_b];
`else
  assign rd_data_a = rd_addr_a == '0 ? '0 : mem[rd_addr_a];
  assign rd_data_b = rd_addr_b == '0 ? '0 : mem[rd_addr_b];
  assign busy_a    = busy[rd_addr_a];
  assign busy_b    = busy[rd_addr_b];
`endif
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors for regfile_scoreboard
module tb_regfile_scoreboard;
  logic        clock, reset, wr_en, rsv_en, flush;
  logic [4:0]  wr_addr, rd_addr_a, rd_addr_b, rsv_addr;
  logic [63:0] wr_data, rd_data_a, rd_data_b;
  logic [7:0]  wr_byte_en;
  logic        busy_a, busy_b;
  int          n_vec = 0, n_err = 0;

  regfile_scoreboard dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .busy_a(busy_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .busy_b(busy_b), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    wr_en = 0; rsv_en = 0; flush = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_byte_en = be;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en = 1; rsv_addr = a;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_addr_a = a; rd_addr_b = b;
    #1;
  endtask

  initial begin
    reset = 0; wr_en = 0; rsv_en = 0; flush = 0;
    wr_addr = 0; wr_data = 0; wr_byte_en = 0; rsv_addr = 0;
    rd_addr_a = 0; rd_addr_b = 0;
    repeat (2) @(posedge clock);
    #1;
    rd(5, 3);
    chk("rst_data_a", rd_data_a, 64'h0);
    chk("rst_busy_a", busy_a, 0);
    reset = 1;
    // reset drop after a write, and in the middle of a second write
    wr(5, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    rsv(5);
    tick();
    rd(5, 5);
    chk("pre_rst_data", rd_data_a, 64'hDEAD_BEEF_0123_4567);
    wr(5, 64'h1111, 8'hFF);
    #1;
    reset = 0;
    #1;
    chk("rst_async_data", rd_data_a, 64'h0);
    chk("rst_async_busy", busy_a, 0);
    tick();
    reset = 1;
    rd(5, 5);
    chk("rst_discard", rd_data_b, 64'h0);
    // byte mask
    wr(3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    tick();
    wr(3, 64'h0, 8'h0F);
    tick();
    rd(0, 3);
    chk("byte_mask", rd_data_b, 64'hFFFF_FFFF_0000_0000);
    // entry 0
    wr(0, 64'h1234, 8'hFF);
    rsv(0);
    tick();
    rd(0, 0);
    chk("r0_data", rd_data_a, 64'h0);
    chk("r0_busy", busy_a, 0);
    // scoreboard
    rsv(7);
    tick();
    rd(7, 7);
    chk("rsv7_busy", busy_a, 1);
    chk("rsv7_busy_b", busy_b, 1);
    wr(7, 64'hAA, 8'hFF);
    tick();
    rd(7, 0);
    chk("wr7_busy", busy_a, 0);
    chk("wr7_data", rd_data_a, 64'hAA);
    wr(9, 64'h99, 8'hFF);
    rsv(9);
    tick();
    rd(9, 9);
    chk("rsv_wr9_busy", busy_a, 1);
    chk("rsv_wr9_data", rd_data_b, 64'h99);
    rsv(11);
    tick();
    wr(11, 64'hFFFF, 8'h00);
    tick();
    rd(11, 11);
    chk("be0_busy", busy_a, 0);
    chk("be0_data", rd_data_b, 64'h0);
    // flush
    rsv(2); tick();
    rsv(4); tick();
    rsv(6); tick();
    rd(2, 6);
    chk("pre_flush_2", busy_a, 1);
    chk("pre_flush_6", busy_b, 1);
    flush = 1;
    rsv(8);
    wr(12, 64'h77, 8'hFF);
    tick();
    rd(2, 4);
    chk("flush_2", busy_a, 0);
    chk("flush_4", busy_b, 0);
    rd(6, 8);
    chk("flush_6", busy_a, 0);
    chk("flush_8", busy_b, 0);
    rd(9, 12);
    chk("flush_9", busy_a, 0);
    chk("flush_wr12", rd_data_b, 64'h77);
    // write-to-read in the same cycle
    wr(10, 64'h55, 8'hFF);
    rd(10, 10);
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_a", rd_data_a, 64'h55);
`else
    chk("same_cycle_a", rd_data_a, 64'h0);
`endif
    tick();
    rd(10, 10);
    chk("next_cycle_a", rd_data_a, 64'h55);
    chk("next_cycle_b", rd_data_b, 64'h55);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
